mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_port_sel.sv | 33 +++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the main-memory arbiter: FSM encodings, default memory
// word size and a constant-foldable ceil(log2) helper.
package mem_arbiter_pkg;

  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_BUSY = 2'd1;
  localparam logic [1:0] MA_RESP = 2'd2;

  localparam int MAIN_MEMORY_READ_SIZE = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_sel.sv
// Combinational winner select: fixed priority (lowest index) or round-robin
// starting at ptr. Produces a one-hot grant and the matching binary index.
module mem_port_sel #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 0,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     index
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (RR_MODE != 0) ? PTR_W'((int'(ptr) + i) % NUM_PORTS) : PTR_W'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Registered request/response arbiter between NUM_PORTS requesters and one
// main-memory port, with a BUSY timeout that recovers from a stalled memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = MAIN_MEMORY_READ_SIZE,
  parameter int RR_MODE   = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_re,
  output logic                        mem_wr,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     sel;
  logic                 sel_we;
  logic [CNT_W-1:0]     count;
  logic [NUM_PORTS-1:0] win_grant;
  logic [PTR_W-1:0]     win_idx;

  mem_port_sel #(
    .NUM_PORTS (NUM_PORTS),
    .RR_MODE   (RR_MODE),
    .PTR_W     (PTR_W)
  ) u_sel (
    .req   (req),
    .ptr   (ptr),
    .grant (win_grant),
    .index (win_idx)
  );

  // NOTE: sequential state is assigned with <= only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= MA_IDLE;
      ptr       <= '0;
      sel       <= '0;
      sel_we    <= 1'b0;
      count     <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_wr    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        MA_IDLE: begin
          if (|win_grant) begin
            sel       <= win_idx;
            sel_we    <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            mem_re    <= ~req_we[win_idx];
            mem_wr    <= req_we[win_idx];
            count     <= '0;
            ptr       <= (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
            state     <= MA_BUSY;
          end
        end
        MA_BUSY: begin
          if (mem_ready) begin
            mem_re    <= 1'b0;
            mem_wr    <= 1'b0;
            rsp_rdata <= sel_we ? '0 : mem_rdata;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_PORTS'(1) << sel;
            state     <= MA_RESP;
          end else if (TIMEOUT != 0 && count == CNT_LAST) begin
            // Abort after TIMEOUT strobe cycles without completion.
            mem_re    <= 1'b0;
            mem_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_PORTS'(1) << sel;
            state     <= MA_RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        MA_RESP: state <= MA_IDLE;
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter (TIMEOUT 8) and a 4-port
// round-robin arbiter share clk/rst; expectations are hand-computed constants.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  f_req, f_we, f_rsp_valid;
  logic [63:0] f_addr, f_wdata;
  logic        f_rsp_err, f_mem_re, f_mem_wr, f_ready;
  logic [31:0] f_rsp_rdata, f_mem_addr, f_mem_wdata, f_rdata;

  logic [3:0]   r_req, r_we, r_rsp_valid;
  logic [127:0] r_addr, r_wdata;
  logic         r_rsp_err, r_mem_re, r_mem_wr, r_ready;
  logic [31:0]  r_rsp_rdata, r_mem_addr, r_mem_wdata, r_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(8)) u_fix (
    .clk(clk), .rst(rst), .req(f_req), .req_we(f_we), .req_addr(f_addr),
    .req_wdata(f_wdata), .rsp_valid(f_rsp_valid), .rsp_err(f_rsp_err),
    .rsp_rdata(f_rsp_rdata), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_re(f_mem_re), .mem_wr(f_mem_wr), .mem_ready(f_ready), .mem_rdata(f_rdata)
  );

  mem_arbiter #(.NUM_PORTS(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(255)) u_rr (
    .clk(clk), .rst(rst), .req(r_req), .req_we(r_we), .req_addr(r_addr),
    .req_wdata(r_wdata), .rsp_valid(r_rsp_valid), .rsp_err(r_rsp_err),
    .rsp_rdata(r_rsp_rdata), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_re(r_mem_re), .mem_wr(r_mem_wr), .mem_ready(r_ready), .mem_rdata(r_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_f(input string tag);
    int n;
    n = 0;
    while (!(f_mem_re || f_mem_wr) && n < 8) begin
      step();
      n++;
    end
    check(tag, 96'(f_mem_re | f_mem_wr), 96'(1));
  endtask

  task automatic wait_r(input string tag);
    int n;
    n = 0;
    while (!(r_mem_re || r_mem_wr) && n < 8) begin
      step();
      n++;
    end
    check(tag, 96'(r_mem_re | r_mem_wr), 96'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int n;
    rst     = 1'b1;
    f_req   = 2'b11;
    f_we    = 2'b00;
    f_addr  = {32'h0000_0200, 32'h0000_0100};
    f_wdata = '0;
    f_ready = 1'b0;
    f_rdata = '0;
    r_req   = 4'h0;
    r_we    = 4'h0;
    r_addr  = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    r_wdata = '0;
    r_ready = 1'b0;
    r_rdata = 32'h0BAD_F00D;

    // Reset held with requests pending: everything stays 0.
    repeat (3) step();
    check("rst_strobes", 96'({f_mem_re, f_mem_wr, r_mem_re, r_mem_wr}), 96'(0));
    check("rst_rsp", 96'({f_rsp_valid, f_rsp_err, f_rsp_rdata}), 96'(0));
    check("rst_mem_bus", 96'({f_mem_addr, f_mem_wdata}), 96'(0));

    // First edge after release grants port 0.
    rst = 1'b0;
    step();
    check("first_grant_re", 96'({f_mem_re, f_mem_wr}), 96'(2'b10));
    check("first_grant_addr", 96'(f_mem_addr), 96'(32'h100));
    f_ready = 1'b1;
    f_rdata = 32'hDEAD_BEEF;
    step();
    check("first_rsp_valid", 96'(f_rsp_valid), 96'(2'b01));
    check("first_rsp_data", 96'({f_rsp_err, f_rsp_rdata}), 96'({1'b0, 32'hDEAD_BEEF}));
    check("first_strobe_drop", 96'(f_mem_re), 96'(0));
    f_ready = 1'b0;
    step();
    check("first_rsp_one_cycle", 96'(f_rsp_valid), 96'(0));

    // Port 0 keeps requesting: port 1 must not be granted.
    for (int k = 0; k < 3; k++) begin
      wait_f("prio_grant");
      check("prio_addr", 96'(f_mem_addr), 96'(32'h100));
      f_ready = 1'b1;
      step();
      check("prio_valid", 96'(f_rsp_valid), 96'(2'b01));
      f_ready = 1'b0;
      step();
    end

    f_req   = 2'b10;
    f_rdata = 32'h1234_5678;
    wait_f("p1_grant");
    check("p1_addr", 96'(f_mem_addr), 96'(32'h200));
    f_ready = 1'b1;
    step();
    check("p1_valid", 96'({f_rsp_valid, f_rsp_rdata}), 96'({2'b10, 32'h1234_5678}));
    f_ready = 1'b0;
    f_req   = 2'b00;
    step();

    // Port 1 write with 5 wait states; late req_addr/req_wdata changes ignored.
    f_we           = 2'b10;
    f_addr[63:32]  = 32'h40;
    f_wdata[63:32] = 32'hCAFE_F00D;
    f_req          = 2'b10;
    wait_f("wr_grant");
    f_addr[63:32]  = 32'h44;
    f_wdata[63:32] = 32'h0;
    check("wr_hold", 96'({f_mem_wr, f_mem_re, f_mem_addr, f_mem_wdata}),
          96'({2'b10, 32'h40, 32'hCAFE_F00D}));
    for (int k = 0; k < 5; k++) begin
      step();
      check("wr_hold", 96'({f_mem_wr, f_mem_re, f_mem_addr, f_mem_wdata}),
            96'({2'b10, 32'h40, 32'hCAFE_F00D}));
    end
    f_ready = 1'b1;
    step();
    check("wr_done", 96'({f_rsp_valid, f_rsp_err, f_mem_wr}), 96'({2'b10, 1'b0, 1'b0}));
    f_ready = 1'b0;
    f_req   = 2'b00;
    f_we    = 2'b00;
    step();
    check("wr_rsp_one_cycle", 96'(f_rsp_valid), 96'(0));

    // Port 0 drops req during BUSY and still gets its response.
    f_req   = 2'b01;
    f_rdata = 32'h5A5A_5A5A;
    wait_f("drop_grant");
    f_req = 2'b00;
    step();
    step();
    check("drop_still_busy", 96'(f_mem_re), 96'(1));
    f_ready = 1'b1;
    step();
    check("drop_valid", 96'({f_rsp_valid, f_rsp_rdata}), 96'({2'b01, 32'h5A5A_5A5A}));
    f_ready = 1'b0;
    step();

    // Timeout: memory never answers, strobe high for 8 cycles then abort.
    f_addr[31:0] = 32'h300;
    f_req        = 2'b01;
    wait_f("to_grant");
    hi = 1;
    n  = 0;
    do begin
      step();
      n++;
      if (f_mem_re) hi++;
    end while (f_mem_re && n < 20);
    check("to_strobe_cycles", 96'(hi), 96'(8));
    check("to_rsp", 96'({f_rsp_valid, f_rsp_err, f_rsp_rdata}), 96'({2'b01, 1'b1, 32'h0}));
    f_req = 2'b00;
    step();
    check("to_rsp_one_cycle", 96'(f_rsp_valid), 96'(0));

    // mem_ready while idle is ignored.
    f_ready = 1'b1;
    repeat (3) step();
    check("idle_ready_ignored", 96'({f_rsp_valid, f_mem_re, f_mem_wr}), 96'(0));
    f_ready = 1'b0;

    // Reset mid-BUSY: outputs clear asynchronously and no response follows.
    f_addr[31:0] = 32'h500;
    f_req        = 2'b01;
    wait_f("rst_grant");
    check("rst_grant_addr", 96'(f_mem_addr), 96'(32'h500));
    #2 rst = 1'b1;
    #1;
    check("rst_async", 96'({f_mem_re, f_mem_wr, f_mem_addr}), 96'(0));
    f_req   = 2'b00;
    f_ready = 1'b1;
    step();
    check("rst_no_rsp", 96'(f_rsp_valid), 96'(0));
    rst = 1'b0;
    step();
    check("rst_no_rsp_after", 96'({f_rsp_valid, f_mem_re}), 96'(0));
    f_ready = 1'b0;
    step();

    // Round-robin: all four requesting, grant order 0,1,2,3,0.
    r_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_r("rr_grant");
      check("rr_addr", 96'(r_mem_addr), 96'(32'h1000 + 32'(k % 4) * 32'h10));
      r_ready = 1'b1;
      step();
      check("rr_valid", 96'(r_rsp_valid), 96'(4'b0001 << (k % 4)));
      r_ready = 1'b0;
      step();
    end
    r_req = 4'h0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
